md_sequencer: RTL
=================

Name: md_sequencer

Overview:
- Multi-cycle controller for the M-extension (mul/div) path of the RV32IM core.
- Sits beside the execute stage:
  - Accepts an operation when decode flags md_type with a 3-bit md_operation (funct3 encoding).
  - Holds the pipeline via a stall output while it iterates.
  - Delivers a 32-bit result with a one-cycle valid pulse.
- One shared iterative shift-add/restoring engine serves all eight operations.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  issue request; qualified by md_type from decode.
- md_operation  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op_a  in  XLEN  rs1 value (multiplicand / dividend).
- op_b  in  XLEN  rs2 value (multiplier / divisor).
- flush  in  1  abort the in-flight operation (branch/jump redirect).
- stall  out  1  freeze IF/ID/EX pipeline registers.
- busy  out  1  engine occupied.
- result_valid  out  1  one-cycle pulse when result is final.
- result  out  XLEN  final value; held until next accepted start.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy=0, result_valid=0, result=0.
  - Counter, accumulators and sign flags cleared.
  - stall=0 while in reset.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 and flush=0 at a clock edge:
    - Latch op and operands.
    - Compute operand magnitudes:
      - Signed for MULH/DIV/REM.
      - op_a only for MULHSU.
    - Record result sign:
      - Product sign = sign_a XOR sign_b.
      - Remainder sign = sign of dividend.
    - counter=0 -> CALC.
  - start is ignored while not IDLE.
- CALC (one iteration per cycle, exactly XLEN cycles):
  - Multiply: 2*XLEN product register, shift-add on multiplier LSB.
  - Divide: restoring shift-subtract, producing quotient bit per cycle.
  - At counter=XLEN-1 -> FIX.
- FIX (1 cycle):
  - Apply two's-complement sign correction.
  - Select the output word:
    - Low word for MUL.
    - High word for MULH/MULHSU/MULHU.
    - Quotient for DIV/DIVU.
    - Remainder for REM/REMU.
  - Write result -> DONE.
- DONE (1 cycle): result_valid=1 -> IDLE.
- Latency: start accepted at edge T, result_valid high in cycle T+XLEN+2 (34 cycles for XLEN=32).
- stall is combinational: (state==IDLE & start & ~flush) | (state==CALC) | (state==FIX).
  - Low in DONE so the pipeline advances exactly once with the valid result.
- busy = state != IDLE.
- Divide special cases (RISC-V mandated):
  - Divisor 0:
    - DIV/DIVU quotient = all ones (0xFFFFFFFF).
    - REM/REMU remainder = dividend.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF):
    - DIV = 0x80000000.
    - REM = 0.
  - These values are forced in FIX regardless of the iteration outcome.
- flush in CALC or FIX:
  - Next state IDLE.
  - result unchanged, no result_valid.
- flush in DONE: ignored; the result is already committed.
- flush and start together in IDLE: start is not accepted.
- rst_n deassertion mid-operation: the operation is lost; start fresh from IDLE.
- result keeps its last value across IDLE and flush; it changes only in FIX.

Optional Feature:
- Macro MD_EARLY_OUT_EN.
- Defined:
  - In IDLE, a divide with op_b=0 or signed overflow skips CALC and goes straight to FIX.
  - A multiply with either operand 0 does the same, with result 0.
  - Latency for these cases is 3 cycles (start edge, FIX, DONE pulse).
  - stall covers only the FIX cycle after acceptance.
- Undefined: every operation takes the full XLEN+2 latency; special-case values are still forced in FIX.

Test Plan:
- MUL 7 x -3 (op_a=7, op_b=0xFFFFFFFD) -> result 0xFFFFFFEB, valid 34 cycles after start, stall high for 33 cycles.
- MULH / MULHSU / MULHU with op_a=0x80000000, op_b=0xFFFFFFFF:
  - MULH -> 0x00000000.
  - MULHSU -> 0x80000000.
  - MULHU -> 0x7FFFFFFF.
- DIV -20/6 -> 0xFFFFFFFD; REM -20/6 -> 0xFFFFFFFE; DIVU 20/6 -> 3; REMU 20/6 -> 2.
- Divisor zero and overflow:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
  - With MD_EARLY_OUT_EN these complete in 3 cycles.
- flush asserted in the 10th CALC cycle of DIV 100/7:
  - No result_valid; result keeps its prior value; busy=0 next cycle.
  - A new MUL 3x4 started next cycle -> 12.
- rst_n pulsed low mid-CALC:
  - All outputs 0 immediately (async).
  - After release, start MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.

Source files
------------

// File: rtl/md_sequencer.sv
// Iterative multiply/divide sequencer for the RV32IM M-extension: one shift-add /
// restoring-divide engine shared by all eight ops. Optional MD_EARLY_OUT_EN skips CALC for trivial cases.
module md_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      md_operation,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            stateQ, stateD;
  logic [2:0]        opQ, opD;
  logic [XLEN-1:0]   dividendQ, dividendD;
  logic [XLEN-1:0]   engQ, engD;
  logic [XLEN-1:0]   accQ, accD;
  logic [XLEN-1:0]   loQ, loD;
  logic [CNT_W-1:0]  cntQ, cntD;
  logic              negQ, negD;
  logic              remNegQ, remNegD;
  logic              divZeroQ, divZeroD;
  logic              ovfQ, ovfD;
  logic [XLEN-1:0]   resultQ, resultD;

  logic              isDiv, signA, signB, divZero, overflow, early;
  logic [XLEN-1:0]   magA, magB;
  logic [XLEN:0]     mulSum, divShift;
  logic              divGe;
  logic [XLEN-1:0]   divDiff;
  logic [2*XLEN-1:0] productFix;
  logic [XLEN-1:0]   quotFix, remFix, fixResult;

  // Operand decode for an incoming request: magnitudes and the sign of the final answer
  always_comb begin
    isDiv    = md_operation[2];
    signA    = op_a[XLEN-1] & ((md_operation == OP_MULH) | (md_operation == OP_MULHSU) |
                               (md_operation == OP_DIV)  | (md_operation == OP_REM));
    signB    = op_b[XLEN-1] & ((md_operation == OP_MULH) | (md_operation == OP_DIV) |
                               (md_operation == OP_REM));
    magA     = signA ? -op_a : op_a;
    magB     = signB ? -op_b : op_b;
    divZero  = (op_b == '0);
    overflow = ((md_operation == OP_DIV) | (md_operation == OP_REM)) &
               (op_a == MOST_NEG) & (op_b == '1);
`ifdef MD_EARLY_OUT_EN
    early    = isDiv ? (divZero | overflow) : ((op_a == '0) | (op_b == '0));
`else
    early    = 1'b0;
`endif
  end

  // One engine step; the product lives in {accQ, loQ}, the divider keeps remainder in accQ and quotient in loQ
  always_comb begin
    mulSum   = {1'b0, accQ} + (loQ[0] ? {1'b0, engQ} : '0);
    divShift = {accQ, loQ[XLEN-1]};
    divGe    = (divShift >= {1'b0, engQ});
    divDiff  = divShift[XLEN-1:0] - engQ;
  end

  always_comb begin
    productFix = negQ ? -{accQ, loQ} : {accQ, loQ};
    quotFix    = negQ ? -loQ : loQ;
    remFix     = remNegQ ? -accQ : accQ;
    fixResult  = '0;
    case (opQ)
      OP_MUL:                       fixResult = productFix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fixResult = productFix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fixResult = divZeroQ ? '1 : (ovfQ ? MOST_NEG : quotFix);
      OP_REM, OP_REMU:              fixResult = divZeroQ ? dividendQ : (ovfQ ? '0 : remFix);
      default:                      fixResult = '0;
    endcase
  end

  always_comb begin
    stateD    = stateQ;
    opD       = opQ;
    dividendD = dividendQ;
    engD      = engQ;
    accD      = accQ;
    loD       = loQ;
    cntD      = cntQ;
    negD      = negQ;
    remNegD   = remNegQ;
    divZeroD  = divZeroQ;
    ovfD      = ovfQ;
    resultD   = resultQ;
    case (stateQ)
      IDLE: begin
        if (start && !flush) begin
          opD       = md_operation;
          dividendD = op_a;
          negD      = signA ^ signB;
          remNegD   = signA;
          divZeroD  = divZero;
          ovfD      = overflow;
          cntD      = '0;
          accD      = '0;
          engD      = isDiv ? magB : magA;
          loD       = early ? '0 : (isDiv ? magA : magB);
          stateD    = early ? FIX : CALC;
        end
      end
      CALC: begin
        if (flush) begin
          stateD = IDLE;
        end else begin
          if (opQ[2]) begin
            accD = divGe ? divDiff : divShift[XLEN-1:0];
            loD  = {loQ[XLEN-2:0], divGe};
          end else begin
            accD = mulSum[XLEN:1];
            loD  = {mulSum[0], loQ[XLEN-1:1]};
          end
          cntD = cntQ + CNT_W'(1);
          if (cntQ == CNT_W'(XLEN-1)) stateD = FIX;
        end
      end
      FIX: begin
        if (flush) begin
          stateD = IDLE;
        end else begin
          resultD = fixResult;
          stateD  = DONE;
        end
      end
      DONE:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= IDLE;
      opQ       <= '0;
      dividendQ <= '0;
      engQ      <= '0;
      accQ      <= '0;
      loQ       <= '0;
      cntQ      <= '0;
      negQ      <= 1'b0;
      remNegQ   <= 1'b0;
      divZeroQ  <= 1'b0;
      ovfQ      <= 1'b0;
      resultQ   <= '0;
    end else begin
      stateQ    <= stateD;
      opQ       <= opD;
      dividendQ <= dividendD;
      engQ      <= engD;
      accQ      <= accD;
      loQ       <= loD;
      cntQ      <= cntD;
      negQ      <= negD;
      remNegQ   <= remNegD;
      divZeroQ  <= divZeroD;
      ovfQ      <= ovfD;
      resultQ   <= resultD;
    end
  end

  // Stall drops in DONE so the pipeline advances exactly once with the result
  assign stall = rst_n & (((stateQ == IDLE) & start & ~flush) | (stateQ == CALC) | (stateQ == FIX));
  assign busy         = (stateQ != IDLE);
  assign result_valid = (stateQ == DONE);
  assign result       = resultQ;

endmodule
